// File: rtl/ex_mem_skid_reg_pkg.sv
// Shared processor definitions: datapath widths, EX/MEM control-bit layout,
// ALU op codes and the EX/MEM occupancy state type.
package proc_pkg;

  localparam int DATA_W  = 16;
  localparam int RADDR_W = 3;
  localparam int CTRL_W  = 5;

  // ctrl vector is {branch, mem_read, mem_write, reg_write, mem_to_reg}
  localparam int CTRL_BRANCH     = 4;
  localparam int CTRL_MEM_READ   = 3;
  localparam int CTRL_MEM_WRITE  = 2;
  localparam int CTRL_REG_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_state_t;

endpackage

// File: rtl/ex_mem_skid_reg_if.sv
// EX->MEM handshake bundle. Handshake rule: an entry moves across a side on a
// rising clock edge exactly when that side's valid and ready are both high.
interface ex_mem_skid_reg_if #(
  parameter int DATA_W  = proc_pkg::DATA_W,
  parameter int RADDR_W = proc_pkg::RADDR_W,
  parameter int CTRL_W  = proc_pkg::CTRL_W
);
  logic               ex_valid;
  logic               ex_ready;
  logic [DATA_W-1:0]  ex_result;
  logic               ex_zero;
  logic [DATA_W-1:0]  ex_sdata;
  logic [RADDR_W-1:0] ex_rd;
  logic [CTRL_W-1:0]  ex_ctrl;

  logic               mem_valid;
  logic               mem_ready;
  logic [DATA_W-1:0]  mem_result;
  logic               mem_zero;
  logic [DATA_W-1:0]  mem_sdata;
  logic [RADDR_W-1:0] mem_rd;
  logic [CTRL_W-1:0]  mem_ctrl;

  logic               fwd_valid;
  logic [RADDR_W-1:0] fwd_rd;
  logic [DATA_W-1:0]  fwd_data;

  // master: the surrounding pipeline (EX producer, MEM consumer, forwarding mux)
  modport master (
    output ex_valid, ex_result, ex_zero, ex_sdata, ex_rd, ex_ctrl, mem_ready,
    input  ex_ready, mem_valid, mem_result, mem_zero, mem_sdata, mem_rd, mem_ctrl,
    input  fwd_valid, fwd_rd, fwd_data
  );

  // slave: the EX/MEM register itself
  modport slave (
    input  ex_valid, ex_result, ex_zero, ex_sdata, ex_rd, ex_ctrl, mem_ready,
    output ex_ready, mem_valid, mem_result, mem_zero, mem_sdata, mem_rd, mem_ctrl,
    output fwd_valid, fwd_rd, fwd_data
  );
endinterface

// File: rtl/ex_mem_skid_reg_slot.sv
// One EX/MEM entry payload register with load enable; clears on reset so the
// head slot drives zeros on the MEM outputs straight out of reset.
module exmem_slot #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM pipeline register as a two-entry skid buffer (head + skid) with a
// registered ex_ready. Optional forwarding tap enabled by `define EXMEM_FWD_EN.
module ex_mem_skid_reg #(
  parameter int DATA_W  = proc_pkg::DATA_W,
  parameter int RADDR_W = proc_pkg::RADDR_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  ex_mem_skid_reg_if.slave     bus,
  output proc_pkg::occ_state_t dbg_state
);
  import proc_pkg::*;

  localparam int ENTRY_W = 2 * DATA_W + 1 + RADDR_W + CTRL_W;

  occ_state_t         state;
  logic               ex_ready_q;
  logic               mem_valid_q;
  logic               accept;
  logic               pop;
  logic               head_load;
  logic               skid_load;
  logic [ENTRY_W-1:0] ex_entry;
  logic [ENTRY_W-1:0] head_d;
  logic [ENTRY_W-1:0] head_q;
  logic [ENTRY_W-1:0] skid_q;

  assign accept   = bus.ex_valid & ex_ready_q;
  assign pop      = mem_valid_q & bus.mem_ready;
  assign ex_entry = {bus.ex_result, bus.ex_zero, bus.ex_sdata, bus.ex_rd, bus.ex_ctrl};

  // Head refills from skid when draining FULL, otherwise straight from EX.
  assign head_d    = (state == ST_FULL) ? skid_q : ex_entry;
  assign head_load = !flush && (((state == ST_EMPTY) && accept) ||
                                ((state == ST_ONE) && accept && pop) ||
                                ((state == ST_FULL) && pop));
  assign skid_load = !flush && (state == ST_ONE) && accept && !pop;

  exmem_slot #(.W(ENTRY_W)) u_head (
    .clock (clock),
    .reset (reset),
    .load  (head_load),
    .d     (head_d),
    .q     (head_q)
  );

  exmem_slot #(.W(ENTRY_W)) u_skid (
    .clock (clock),
    .reset (reset),
    .load  (skid_load),
    .d     (ex_entry),
    .q     (skid_q)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= ST_EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= ST_EMPTY;
      ex_ready_q  <= 1'b1;
      mem_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state       <= ST_ONE;
            mem_valid_q <= 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state      <= ST_FULL;
            ex_ready_q <= 1'b0;
          end else if (!accept && pop) begin
            state       <= ST_EMPTY;
            mem_valid_q <= 1'b0;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state      <= ST_ONE;
            ex_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= ST_EMPTY;
          ex_ready_q  <= 1'b1;
          mem_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ex_ready  = ex_ready_q;
  assign bus.mem_valid = mem_valid_q;
  assign {bus.mem_result, bus.mem_zero, bus.mem_sdata, bus.mem_rd, bus.mem_ctrl} = head_q;
  assign dbg_state     = state;

`ifdef EXMEM_FWD_EN
  // Loads are excluded: their value only exists after the MEM stage.
  assign bus.fwd_valid = mem_valid_q & bus.mem_ctrl[CTRL_REG_WRITE] & ~bus.mem_ctrl[CTRL_MEM_READ];
  assign bus.fwd_rd    = bus.mem_rd;
  assign bus.fwd_data  = bus.mem_result;
`else
  assign bus.fwd_valid = 1'b0;
  assign bus.fwd_rd    = '0;
  assign bus.fwd_data  = '0;
`endif

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed vector table, FIFO-order stream with a
// scoreboard queue, async reset mid-stream, and the forwarding tap.
module tb_ex_mem_skid_reg;

  logic clock;
  logic reset;
  logic flush;
  proc_pkg::occ_state_t dbg_state;

  ex_mem_skid_reg_if bus ();

  ex_mem_skid_reg dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // driver tasks
  task automatic drive(input logic ev, input logic fl, input logic mr,
                       input logic [15:0] res, input logic [2:0] rd, input logic [4:0] ctrl);
    bus.ex_valid  = ev;
    flush         = fl;
    bus.mem_ready = mr;
    bus.ex_result = res;
    bus.ex_zero   = (res == 16'h0000);
    bus.ex_sdata  = res ^ 16'hFFFF;
    bus.ex_rd     = rd;
    bus.ex_ctrl   = ctrl;
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic chk_fwd(input string nm, input logic v, input logic [2:0] rd, input logic [15:0] d);
`ifdef EXMEM_FWD_EN
    chk({nm, "_fwd_valid"}, 32'(bus.fwd_valid), 32'(v));
    chk({nm, "_fwd_rd"},    32'(bus.fwd_rd),    32'(rd));
    chk({nm, "_fwd_data"},  32'(bus.fwd_data),  32'(d));
`else
    chk({nm, "_fwd_valid"}, 32'(bus.fwd_valid), 32'(1'b0 & v));
    chk({nm, "_fwd_rd"},    32'(bus.fwd_rd),    32'(3'd0 & rd));
    chk({nm, "_fwd_data"},  32'(bus.fwd_data),  32'(16'd0 & d));
`endif
  endtask

  typedef struct {
    logic        ev;
    logic        fl;
    logic        mr;
    logic [15:0] res;
    logic [2:0]  rd;
    logic [4:0]  ctrl;
    logic        chk_data;
    logic        e_valid;
    logic        e_ready;
    logic [1:0]  e_state;
    logic [15:0] e_res;
    logic [2:0]  e_rd;
    logic [4:0]  e_ctrl;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // ev fl mr  res       rd    ctrl      chk | valid ready state  e_res     e_rd  e_ctrl
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'h1234, 3'd3, 5'b00010, 1'b1, 1'b1, 1'b1, 2'd1, 16'h1234, 3'd3, 5'b00010};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h1234, 3'd3, 5'b00010};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h0001, 3'd1, 5'b00100, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0001, 3'd1, 5'b00100};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0002, 3'd2, 5'b01011, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0001, 3'd1, 5'b00100};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h0003, 3'd3, 5'b10000, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0001, 3'd1, 5'b00100};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 16'h0003, 3'd3, 5'b10000, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0002, 3'd2, 5'b01011};
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'h000C, 3'd4, 5'b00010, 1'b1, 1'b1, 1'b1, 2'd1, 16'h000C, 3'd4, 5'b00010};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h000C, 3'd4, 5'b00010};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 3'd5, 5'b00010, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0011, 3'd5, 5'b00010};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'h0022, 3'd6, 5'b00011, 1'b1, 1'b1, 1'b0, 2'd2, 16'h0011, 3'd5, 5'b00010};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h0033, 3'd7, 5'b00001, 1'b0, 1'b0, 1'b1, 2'd0, 16'h0000, 3'd0, 5'b00000};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 16'h0044, 3'd1, 5'b00110, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0044, 3'd1, 5'b00110};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0044, 3'd1, 5'b00110};
    vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b1, 1'b1, 1'b1, 2'd1, 16'h0000, 3'd0, 5'b00000};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 16'h0000, 3'd0, 5'b00000, 1'b1, 1'b0, 1'b1, 2'd0, 16'h0000, 3'd0, 5'b00000};

    drive(1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 5'd0);
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // reset state
    chk("rst_mem_valid",  32'(bus.mem_valid),  32'd0);
    chk("rst_ex_ready",   32'(bus.ex_ready),   32'd1);
    chk("rst_mem_result", 32'(bus.mem_result), 32'd0);
    chk("rst_mem_sdata",  32'(bus.mem_sdata),  32'd0);
    chk("rst_mem_rd",     32'(bus.mem_rd),     32'd0);
    chk("rst_mem_ctrl",   32'(bus.mem_ctrl),   32'd0);
    chk("rst_state",      32'(dbg_state),      32'd0);
    chk_fwd("rst", 1'b0, 3'd0, 16'h0);

    // directed vector table
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ev, vecs[i].fl, vecs[i].mr, vecs[i].res, vecs[i].rd, vecs[i].ctrl);
      step();
      chk($sformatf("v%0d_mem_valid", i), 32'(bus.mem_valid), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_ex_ready", i),  32'(bus.ex_ready),  32'(vecs[i].e_ready));
      chk($sformatf("v%0d_state", i),     32'(dbg_state),     32'(vecs[i].e_state));
      if (vecs[i].chk_data) begin
        chk($sformatf("v%0d_mem_result", i), 32'(bus.mem_result), 32'(vecs[i].e_res));
        chk($sformatf("v%0d_mem_sdata", i),  32'(bus.mem_sdata),  32'(vecs[i].e_res ^ 16'hFFFF));
        chk($sformatf("v%0d_mem_zero", i),   32'(bus.mem_zero),   32'(vecs[i].e_res == 16'h0));
        chk($sformatf("v%0d_mem_rd", i),     32'(bus.mem_rd),     32'(vecs[i].e_rd));
        chk($sformatf("v%0d_mem_ctrl", i),   32'(bus.mem_ctrl),   32'(vecs[i].e_ctrl));
        chk_fwd($sformatf("v%0d", i),
                vecs[i].e_valid & vecs[i].e_ctrl[1] & ~vecs[i].e_ctrl[3],
                vecs[i].e_rd, vecs[i].e_res);
      end
    end

    // FIFO-order stream with random MEM stalls
    begin
      int sent = 0;
      int recv = 0;
      int cyc  = 0;
      logic acc, pp;
      exp_q.delete();
      while (recv < 20 && cyc < 400) begin
        chk("stream_mem_valid", 32'(bus.mem_valid), 32'(exp_q.size() > 0));
        chk("stream_ex_ready",  32'(bus.ex_ready),  32'(exp_q.size() < 2));
        drive(sent < 20, 1'b0, 1'($urandom_range(0, 1)), 16'(16'h0100 + sent), 3'(sent), 5'b00010);
        acc = bus.ex_valid & bus.ex_ready;
        pp  = bus.mem_valid & bus.mem_ready;
        if (pp) begin
          if (exp_q.size() == 0) chk("stream_underflow", 32'd1, 32'd0);
          else chk("stream_order", 32'(bus.mem_result), 32'(exp_q.pop_front()));
          recv++;
        end
        if (acc) begin
          exp_q.push_back(16'(16'h0100 + sent));
          sent++;
        end
        step();
        cyc++;
      end
      chk("stream_done", 32'(recv), 32'd20);
    end

    // async reset between clocks while FULL
    drive(1'b1, 1'b0, 1'b0, 16'hA5A5, 3'd6, 5'b00111);
    step();
    drive(1'b1, 1'b0, 1'b0, 16'h5A5A, 3'd7, 5'b11000);
    step();
    chk("pre_rst_state", 32'(dbg_state), 32'd2);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 3'd0, 5'd0);
    @(posedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_valid",  32'(bus.mem_valid),  32'd0);
    chk("async_rst_ex_ready",   32'(bus.ex_ready),   32'd1);
    chk("async_rst_mem_result", 32'(bus.mem_result), 32'd0);
    chk("async_rst_mem_rd",     32'(bus.mem_rd),     32'd0);
    chk("async_rst_mem_ctrl",   32'(bus.mem_ctrl),   32'd0);
    chk("async_rst_state",      32'(dbg_state),      32'd0);
    @(negedge clock);
    reset = 1'b0;

    // forwarding tap
    drive(1'b1, 1'b0, 1'b0, 16'hBEEF, 3'd5, 5'b00010);
    step();
    chk_fwd("fwd_alu", 1'b1, 3'd5, 16'hBEEF);
    drive(1'b1, 1'b0, 1'b1, 16'hBEEF, 3'd5, 5'b01010);
    step();
    chk("fwd_load_mem_ctrl", 32'(bus.mem_ctrl), 32'(5'b01010));
    chk_fwd("fwd_load", 1'b0, 3'd5, 16'hBEEF);
    drive(1'b0, 1'b0, 1'b1, 16'h0, 3'd0, 5'd0);
    step();
    chk_fwd("fwd_empty", 1'b0, 3'd5, 16'hBEEF);
    chk("fwd_empty_valid", 32'(bus.mem_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
